// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB pipeline stage: payload layout, skid-buffer
// state encoding and the occupancy decode.
package mem_wb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int OCC_W      = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [DATA_W_DEF-1:0] alu_result;
      logic [ADDR_W_DEF-1:0] write_reg;
      logic [DATA_W_DEF-1:0] read_data;
   } wb_payload_t;

   function automatic logic [OCC_W-1:0] occupancyOf(input skid_state_t s);
      case (s)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_mem_wb_if.sv
// MEM-side and WB-side handshake/payload bundle of the MEM/WB stage.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface pipe_stage_mem_wb_if
   import mem_wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic              in_valid;
   logic              in_ready;
   logic              in_reg_write;
   logic              in_mem_to_reg;
   logic [DATA_W-1:0] in_alu_result;
   logic [ADDR_W-1:0] in_write_reg;
   logic [DATA_W-1:0] in_read_data;

   logic              out_valid;
   logic              out_ready;
   logic              out_reg_write;
   logic              out_mem_to_reg;
   logic [DATA_W-1:0] out_alu_result;
   logic [ADDR_W-1:0] out_write_reg;
   logic [DATA_W-1:0] out_read_data;
   logic [DATA_W-1:0] out_wb_data;
   logic [OCC_W-1:0]  occupancy;

   modport slave (
      input  in_valid, in_reg_write, in_mem_to_reg, in_alu_result, in_write_reg,
             in_read_data, out_ready,
      output in_ready, out_valid, out_reg_write, out_mem_to_reg, out_alu_result,
             out_write_reg, out_read_data, out_wb_data, occupancy
   );

   modport master (
      output in_valid, in_reg_write, in_mem_to_reg, in_alu_result, in_write_reg,
             in_read_data, out_ready,
      input  in_ready, out_valid, out_reg_write, out_mem_to_reg, out_alu_result,
             out_write_reg, out_read_data, out_wb_data, occupancy
   );

endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: a main register driving the outputs plus one skid
// register, so inReady comes straight from a flop and never from outReady.
module pipe_skid_buffer
   import mem_wb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inData,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] outData,
   output logic [OCC_W-1:0] occupancy
);

   skid_state_t      state;
   logic [WIDTH-1:0] mainQ;
   logic [WIDTH-1:0] skidQ;
   logic             inReadyQ;
   logic             inFire;
   logic             outFire;

   assign inFire  = inValid & inReadyQ;
   assign outFire = outValid & outReady;

   // inReadyQ tracks "next state is not TWO", decided in the same branch as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         // NOTE: payload registers are reset as well because the stage outputs must read 0 out of reset.
         mainQ    <= '0;
         skidQ    <= '0;
         inReadyQ <= 1'b0;
      end else if (flush) begin
         state    <= EMPTY;
         inReadyQ <= 1'b1;
      end else begin
         // NOTE: non-blocking everywhere so every branch sees the pre-edge state and data.
         case (state)
            EMPTY: begin
               inReadyQ <= 1'b1;
               if (inFire) begin
                  mainQ <= inData;
                  state <= ONE;
               end
            end
            ONE: begin
               inReadyQ <= 1'b1;
               if (inFire && outFire) begin
                  mainQ <= inData;
               end else if (inFire) begin
                  skidQ    <= inData;
                  state    <= TWO;
                  inReadyQ <= 1'b0;
               end else if (outFire) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               inReadyQ <= 1'b0;
               if (outFire) begin
                  mainQ    <= skidQ;
                  state    <= ONE;
                  inReadyQ <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               inReadyQ <= 1'b1;
            end
         endcase
      end
   end

   assign inReady   = inReadyQ;
   assign outValid  = (state != EMPTY);
   assign outData   = mainQ;
   assign occupancy = occupancyOf(state);

endmodule

// File: rtl/pipe_stage_mem_wb.sv
// MEM/WB pipeline register built on the skid buffer, adding the write-back
// data select and the register-0 write guard.
module pipe_stage_mem_wb
   import mem_wb_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter bit ZERO_REG_GUARD = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush,
   pipe_stage_mem_wb_if.slave bus
);

   // Parameter-sized twin of wb_payload_t; identical layout at the default widths.
   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [DATA_W-1:0] alu_result;
      logic [ADDR_W-1:0] write_reg;
      logic [DATA_W-1:0] read_data;
   } payload_t;

   payload_t inPayload;
   payload_t mainPayload;
   logic     regZeroHit;

   assign inPayload = '{
      reg_write:  bus.in_reg_write,
      mem_to_reg: bus.in_mem_to_reg,
      alu_result: bus.in_alu_result,
      write_reg:  bus.in_write_reg,
      read_data:  bus.in_read_data
   };

   pipe_skid_buffer #(
      .WIDTH($bits(payload_t))
   ) uSkid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .inValid  (bus.in_valid),
      .inReady  (bus.in_ready),
      .inData   (inPayload),
      .outValid (bus.out_valid),
      .outReady (bus.out_ready),
      .outData  (mainPayload),
      .occupancy(bus.occupancy)
   );

   // Stale data survives a flush, so the write enable must be qualified by out_valid.
   assign regZeroHit        = ZERO_REG_GUARD && (mainPayload.write_reg == '0);
   assign bus.out_reg_write = mainPayload.reg_write & bus.out_valid & ~regZeroHit;

   assign bus.out_mem_to_reg = mainPayload.mem_to_reg;
   assign bus.out_alu_result = mainPayload.alu_result;
   assign bus.out_write_reg  = mainPayload.write_reg;
   assign bus.out_read_data  = mainPayload.read_data;
   assign bus.out_wb_data    = mainPayload.mem_to_reg ? mainPayload.read_data
                                                      : mainPayload.alu_result;

endmodule

// File: tb/tb_pipe_stage_mem_wb.sv
// Bench for pipe_stage_mem_wb: directed scenarios on a default instance, then
// random traffic on it and on a 16/6-bit unguarded instance, scoreboard-checked.
module tb_pipe_stage_mem_wb;

   localparam bit GUARD_A = 1'b1;
   localparam bit GUARD_B = 1'b0;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [7:0]  wr;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flushA;
   logic flushB;
   bit   sinceReset = 1'b1;

   int nCompared   = 0;
   int nMismatched = 0;

   txn_t qA[$];
   txn_t qB[$];

   pipe_stage_mem_wb_if #(.DATA_W(32), .ADDR_W(5)) busA ();
   pipe_stage_mem_wb_if #(.DATA_W(16), .ADDR_W(6)) busB ();

   pipe_stage_mem_wb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_GUARD(GUARD_A)) dutA (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flushA),
      .bus  (busA.slave)
   );

   pipe_stage_mem_wb #(.DATA_W(16), .ADDR_W(6), .ZERO_REG_GUARD(GUARD_B)) dutB (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flushB),
      .bus  (busB.slave)
   );

   always #5 clk = ~clk;

   // Set while reset is (or has been) asserted and no clock edge has followed yet.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sinceReset <= 1'b1;
      else        sinceReset <= 1'b0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveA(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wr);
      busA.in_valid      = v;
      busA.in_reg_write  = rw;
      busA.in_mem_to_reg = m2r;
      busA.in_alu_result = alu;
      busA.in_read_data  = rd;
      busA.in_write_reg  = wr;
   endtask

   function automatic logic [31:0] expWb(input txn_t t);
      return t.m2r ? t.rd : t.alu;
   endfunction

   function automatic logic expRw(input txn_t t, input bit guard);
      return t.rw && !(guard && (t.wr == 8'd0));
   endfunction

   // Monitor A: the stage behaves as a 2-deep FIFO whose head is always on the outputs.
   always @(negedge clk) begin
      txn_t t;
      if (rst_n) begin
         if (sinceReset) qA.delete();
         check("A occupancy", 64'(busA.occupancy), 64'(qA.size()));
         check("A out_valid", 64'(busA.out_valid), 64'(qA.size() != 0));
         check("A in_ready", 64'(busA.in_ready), 64'(!sinceReset && qA.size() < 2));
         if (qA.size() != 0) begin
            t = qA[0];
            check("A out_wb_data", 64'(busA.out_wb_data), 64'(expWb(t)));
            check("A out_reg_write", 64'(busA.out_reg_write), 64'(expRw(t, GUARD_A)));
            check("A out_write_reg", 64'(busA.out_write_reg), 64'(t.wr));
            if (busA.out_ready) void'(qA.pop_front());
         end else begin
            check("A idle out_reg_write", 64'(busA.out_reg_write), 64'(0));
         end
         if (flushA) begin
            qA.delete();
         end else if (busA.in_valid && busA.in_ready) begin
            t.rw  = busA.in_reg_write;
            t.m2r = busA.in_mem_to_reg;
            t.alu = busA.in_alu_result;
            t.rd  = busA.in_read_data;
            t.wr  = 8'(busA.in_write_reg);
            qA.push_back(t);
         end
      end
   end

   always @(negedge clk) begin
      txn_t t;
      if (rst_n) begin
         if (sinceReset) qB.delete();
         check("B occupancy", 64'(busB.occupancy), 64'(qB.size()));
         check("B out_valid", 64'(busB.out_valid), 64'(qB.size() != 0));
         check("B in_ready", 64'(busB.in_ready), 64'(!sinceReset && qB.size() < 2));
         if (qB.size() != 0) begin
            t = qB[0];
            check("B out_wb_data", 64'(busB.out_wb_data), 64'(expWb(t)));
            check("B out_reg_write", 64'(busB.out_reg_write), 64'(expRw(t, GUARD_B)));
            check("B out_write_reg", 64'(busB.out_write_reg), 64'(t.wr));
            if (busB.out_ready) void'(qB.pop_front());
         end else begin
            check("B idle out_reg_write", 64'(busB.out_reg_write), 64'(0));
         end
         if (flushB) begin
            qB.delete();
         end else if (busB.in_valid && busB.in_ready) begin
            t.rw  = busB.in_reg_write;
            t.m2r = busB.in_mem_to_reg;
            t.alu = 32'(busB.in_alu_result);
            t.rd  = 32'(busB.in_read_data);
            t.wr  = 8'(busB.in_write_reg);
            qB.push_back(t);
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      flushA = 1'b0;
      flushB = 1'b0;
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      busA.out_ready     = 1'b1;
      busB.in_valid      = 1'b0;
      busB.in_reg_write  = 1'b0;
      busB.in_mem_to_reg = 1'b0;
      busB.in_alu_result = 16'h0;
      busB.in_read_data  = 16'h0;
      busB.in_write_reg  = 6'd0;
      busB.out_ready     = 1'b1;

      // Reset state
      #21;
      check("rst out_valid", 64'(busA.out_valid), 64'(0));
      check("rst occupancy", 64'(busA.occupancy), 64'(0));
      check("rst out_reg_write", 64'(busA.out_reg_write), 64'(0));
      check("rst out_wb_data", 64'(busA.out_wb_data), 64'(0));
      check("rst out_write_reg", 64'(busA.out_write_reg), 64'(0));
      #1 rst_n = 1'b1;
      step();
      check("post-rst in_ready", 64'(busA.in_ready), 64'(1));

      // Back-to-back stream with the WB stage always ready
      driveA(1'b1, 1'b1, 1'b0, 32'h0000_00AA, $urandom, 5'd3);
      step();
      check("stream wb0", 64'(busA.out_wb_data), 64'h0000_00AA);
      check("stream occ0", 64'(busA.occupancy), 64'(1));
      check("stream rw0", 64'(busA.out_reg_write), 64'(1));
      driveA(1'b1, 1'b1, 1'b1, $urandom, 32'h1234_5678, 5'd4);
      step();
      check("stream wb1", 64'(busA.out_wb_data), 64'h1234_5678);
      check("stream occ1", 64'(busA.occupancy), 64'(1));
      check("stream wr1", 64'(busA.out_write_reg), 64'(4));
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      step();
      check("stream drained", 64'(busA.out_valid), 64'(0));

      // Stall: two accepts fill the buffer, the third is held off
      busA.out_ready = 1'b0;
      driveA(1'b1, 1'b0, 1'b0, 32'd1, 32'h0, 5'd1);
      step();
      check("stall occ1", 64'(busA.occupancy), 64'(1));
      check("stall ready1", 64'(busA.in_ready), 64'(1));
      driveA(1'b1, 1'b0, 1'b0, 32'd2, 32'h0, 5'd1);
      step();
      check("stall occ2", 64'(busA.occupancy), 64'(2));
      check("stall ready2", 64'(busA.in_ready), 64'(0));
      driveA(1'b1, 1'b0, 1'b0, 32'd3, 32'h0, 5'd1);
      step();
      check("stall occ held", 64'(busA.occupancy), 64'(2));
      check("stall head stable", 64'(busA.out_wb_data), 64'(1));
      busA.out_ready = 1'b1;
      step();
      check("release wb2", 64'(busA.out_wb_data), 64'(2));
      check("release occ", 64'(busA.occupancy), 64'(1));
      step();
      check("release wb3", 64'(busA.out_wb_data), 64'(3));
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      step();
      check("release drained", 64'(busA.out_valid), 64'(0));

      // Flush while full, with a competing input
      busA.out_ready = 1'b0;
      driveA(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
      step();
      driveA(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd5);
      step();
      check("pre-flush occ", 64'(busA.occupancy), 64'(2));
      flushA = 1'b1;
      driveA(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd7);
      step();
      flushA = 1'b0;
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      check("flush out_valid", 64'(busA.out_valid), 64'(0));
      check("flush out_reg_write", 64'(busA.out_reg_write), 64'(0));
      check("flush occ", 64'(busA.occupancy), 64'(0));
      check("flush in_ready", 64'(busA.in_ready), 64'(1));
      busA.out_ready = 1'b1;
      step();
      check("flush input dropped", 64'(busA.out_valid), 64'(0));

      // Register-0 guard: enabled on A, disabled on B
      driveA(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd0);
      busB.in_valid      = 1'b1;
      busB.in_reg_write  = 1'b1;
      busB.in_mem_to_reg = 1'b0;
      busB.in_alu_result = 16'h0055;
      busB.in_write_reg  = 6'd0;
      step();
      check("guard A valid", 64'(busA.out_valid), 64'(1));
      check("guard A rw", 64'(busA.out_reg_write), 64'(0));
      check("guard B valid", 64'(busB.out_valid), 64'(1));
      check("guard B rw", 64'(busB.out_reg_write), 64'(1));
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      busB.in_valid = 1'b0;
      step();

      // Asynchronous reset between clock edges while full
      busA.out_ready = 1'b0;
      driveA(1'b1, 1'b1, 1'b0, 32'h21, 32'h0, 5'd9);
      step();
      driveA(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd9);
      step();
      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      check("pre-reset occ", 64'(busA.occupancy), 64'(2));
      #1 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 64'(busA.out_valid), 64'(0));
      check("async rst occ", 64'(busA.occupancy), 64'(0));
      check("async rst rw", 64'(busA.out_reg_write), 64'(0));
      #1 rst_n = 1'b1;
      busA.out_ready = 1'b1;
      step();
      check("post async in_ready", 64'(busA.in_ready), 64'(1));
      check("post async out_valid", 64'(busA.out_valid), 64'(0));

      // Random traffic on both instances
      for (int c = 0; c < 10000; c++) begin
         driveA($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom_range(0, 7)));
         busA.out_ready     = ($urandom_range(0, 2) != 0);
         flushA             = ($urandom_range(0, 199) == 0);
         busB.in_valid      = ($urandom_range(0, 3) != 0);
         busB.in_reg_write  = 1'($urandom);
         busB.in_mem_to_reg = 1'($urandom);
         busB.in_alu_result = 16'($urandom);
         busB.in_read_data  = 16'($urandom);
         busB.in_write_reg  = 6'($urandom_range(0, 7));
         busB.out_ready     = ($urandom_range(0, 1) != 0);
         flushB             = ($urandom_range(0, 199) == 0);
         step();
      end

      driveA(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      busA.out_ready = 1'b1;
      busB.in_valid  = 1'b0;
      busB.out_ready = 1'b1;
      flushA         = 1'b0;
      flushB         = 1'b0;
      repeat (4) step();
      check("A drained", 64'(qA.size()), 64'(0));
      check("B drained", 64'(qB.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/pipe_stage_mem_wb.md
Name: pipe_stage_mem_wb

Overview:
Parametrised MEM/WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Lets the write-back stage stall without combinational ready paths back into MEM.
- Supports synchronous flush (bubble insertion) and an optional register-0 write guard.
- Provides the selected write-back data (ALU result or load data) as a registered-path mux output.
- Sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of ALU result, load data and write-back data
ADDR_W, 5, width of destination register index
ZERO_REG_GUARD, 1, 1 = force out_reg_write low when out_write_reg == 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  MEM stage presents a valid instruction
in_ready  out  1  stage can accept; registered (no comb path from out_ready)
in_reg_write  in  1  control: write register file
in_mem_to_reg  in  1  control: 1 = write back load data, 0 = ALU result
in_alu_result  in  DATA_W  ALU result from MEM
in_write_reg  in  ADDR_W  destination register index
in_read_data  in  DATA_W  data-memory read data
out_valid  out  1  WB stage entry valid
out_ready  in  1  WB stage consumes entry this cycle
out_reg_write  out  1  registered reg_write, gated by out_valid and guard
out_mem_to_reg  out  1  registered mem_to_reg
out_alu_result  out  DATA_W  registered ALU result
out_write_reg  out  ADDR_W  registered destination index
out_read_data  out  DATA_W  registered load data
out_wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_result
occupancy  out  2  held entries, 0..2

Behaviour:
- Reset (rst_n low, async):
  - State goes to EMPTY.
  - out_valid=0, out_reg_write=0, all data/control outputs 0, occupancy=0.
  - in_ready=1 from the first clock after deassertion.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency from in_fire to out_valid is 1 cycle.
  - Throughput is 1 per cycle while out_ready stays high.
- Storage: main register (drives outputs) plus skid register. States are EMPTY, ONE, TWO.
- EMPTY:
  - in_fire: main<=input, go to ONE.
- ONE:
  - in_fire & out_fire: main<=input, stay in ONE.
  - in_fire & !out_ready: skid<=input, go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- TWO:
  - in_ready=0.
  - out_fire: main<=skid, go to ONE.
  - Otherwise hold.
- in_ready is registered: in_ready = (next_state != TWO), registered.
- Outputs stay stable while out_valid & !out_ready. No entry is ever lost or duplicated.
- Flush:
  - Next state EMPTY; out_valid=0; skid invalidated; in_ready=1 next cycle.
  - Flush has priority over a simultaneous in_fire; that input is dropped.
  - Data registers may keep stale values, but out_reg_write must be 0.
- out_reg_write = main.reg_write & out_valid & !(ZERO_REG_GUARD & (out_write_reg == 0)).
- out_wb_data is a pure mux of main-register fields; no extra latency.
- Reset asserted mid-operation clears both entries immediately, independent of clk.
- occupancy: EMPTY=0, ONE=1, TWO=2.

Decomposition:
- Package mem_wb_pkg holds:
  - wb_payload_t: packed struct {reg_write, mem_to_reg, alu_result, write_reg, read_data}, sized by the DATA_W/ADDR_W defaults.
  - skid_state_t enum: EMPTY, ONE, TWO.
- Natural sub-module pipe_skid_buffer: generic over payload width, holds the state machine, main/skid registers and flush.
- pipe_stage_mem_wb wraps pipe_skid_buffer and adds the write-back mux and reg-0 guard.

Test Plan:
- Reset, then stream with out_ready=1:
  - Stimulus: in {rw=1, m2r=0, alu=0x0000_00AA, wr=3}, then {rw=1, m2r=1, rd=0x1234_5678, wr=4} on consecutive cycles.
  - Response: out_wb_data = 0xAA, then 0x1234_5678, one cycle after each input; occupancy stays 1.
- Stall:
  - Stimulus: out_ready=0 with in_valid=1 for 3 cycles (alu 1, 2, 3).
  - Response: occupancy goes 1 then 2; in_ready low from the cycle after the second accept; the third value is not accepted.
  - Release: out_ready=1; outputs deliver 1, 2, 3 in order with no loss or duplication.
- Flush:
  - Stimulus: flush asserted in state TWO together with in_valid=1.
  - Response: next cycle out_valid=0, out_reg_write=0, occupancy=0, in_ready=1; the concurrent input does not appear.
- Zero-register guard:
  - Stimulus: input {rw=1, wr=0}.
  - Response: out_valid=1, out_reg_write=0 with ZERO_REG_GUARD=1; out_reg_write=1 with ZERO_REG_GUARD=0.
- Async reset mid-stall:
  - Stimulus: rst_n pulsed low between clock edges while occupancy=2.
  - Response: out_valid=0 and occupancy=0 immediately, before the next clk edge.
- Parameter sweep:
  - Stimulus: DATA_W=16, ADDR_W=6, random in_valid/out_ready for 10k cycles.
  - Response: the output sequence equals the accepted input sequence, checked by a scoreboard.
